// File: rtl/ibex_pkg.sv
// Shared types for the multiply/divide issue sequencer: unit operator codes,
// requester op codes, sequencer states and the op -> operator/signedness decode.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    MD_REQ_MUL    = 3'd0,
    MD_REQ_MULH   = 3'd1,
    MD_REQ_MULHSU = 3'd2,
    MD_REQ_MULHU  = 3'd3,
    MD_REQ_DIV    = 3'd4,
    MD_REQ_DIVU   = 3'd5,
    MD_REQ_REM    = 3'd6,
    MD_REQ_REMU   = 3'd7
  } md_req_op_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_EXEC = 2'd1,
    SEQ_RESP = 2'd2
  } seq_state_e;

  typedef struct packed {
    md_op_e     op;
    logic [1:0] signed_mode;
  } md_decode_t;

  // signed_mode bit0 marks operand a as signed, bit1 marks operand b as signed.
  function automatic md_decode_t md_decode(input md_req_op_e req_op);
    md_decode_t dec;
    dec.op          = MD_OP_MULL;
    dec.signed_mode = 2'b00;
    case (req_op)
      MD_REQ_MUL:    begin dec.op = MD_OP_MULL; dec.signed_mode = 2'b00; end
      MD_REQ_MULH:   begin dec.op = MD_OP_MULH; dec.signed_mode = 2'b11; end
      MD_REQ_MULHSU: begin dec.op = MD_OP_MULH; dec.signed_mode = 2'b01; end
      MD_REQ_MULHU:  begin dec.op = MD_OP_MULH; dec.signed_mode = 2'b00; end
      MD_REQ_DIV:    begin dec.op = MD_OP_DIV;  dec.signed_mode = 2'b11; end
      MD_REQ_DIVU:   begin dec.op = MD_OP_DIV;  dec.signed_mode = 2'b00; end
      MD_REQ_REM:    begin dec.op = MD_OP_REM;  dec.signed_mode = 2'b11; end
      MD_REQ_REMU:   begin dec.op = MD_OP_REM;  dec.signed_mode = 2'b00; end
      default:       begin dec.op = MD_OP_MULL; dec.signed_mode = 2'b00; end
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/ibex_multdiv_arb.sv
// Two-way priority arbiter: core (bit0) normally wins, BIST (bit1) is forced
// through after STARVE_LIMIT consecutive core grants taken while it waited.
module ibex_multdiv_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       arb_en_i,
  input  logic [1:0] req_valid_i,
  output logic [1:0] grant_o
);

  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             bist_wins;

  assign bist_wins = req_valid_i[1] && (!req_valid_i[0] || (starve_cnt_q == CNT_MAX));

  always_comb begin
    grant_o = '0;
    if (arb_en_i) begin
      if (bist_wins) begin
        grant_o = 2'b10;
      end else if (req_valid_i[0]) begin
        grant_o = 2'b01;
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_o[1]) begin
      starve_cnt_d = '0;
    end else if (grant_o[0] && req_valid_i[1] && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/ibex_multdiv_sequencer.sv
// Issue controller in front of ibex_multdiv_fast: arbitrates core/BIST,
// drives the unit, owns its intermediate registers and returns the result.
module ibex_multdiv_sequencer
  import ibex_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0][2:0]  req_op_i,
  input  logic [1:0][31:0] req_a_i,
  input  logic [1:0][31:0] req_b_i,
  output logic [1:0]       rsp_valid_o,
  input  logic [1:0]       rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  input  logic             data_ind_timing_i,
  output logic             mult_en_o,
  output logic             div_en_o,
  output logic             mult_sel_o,
  output logic             div_sel_o,
  output logic [1:0]       operator_o,
  output logic [1:0]       signed_mode_o,
  output logic [31:0]      op_a_o,
  output logic [31:0]      op_b_o,
  output logic             equal_to_zero_o,
  input  logic             valid_i,
  input  logic [31:0]      result_i,
  input  logic [33:0]      imd_val_d_i_0,
  input  logic [33:0]      imd_val_d_i_1,
  input  logic [1:0]       imd_val_we_i,
  output logic [33:0]      imd_val_q_o_0,
  output logic [33:0]      imd_val_q_o_1,
  output logic             busy_o,
  output logic             timeout_err_o,
  input  logic             err_clr_i
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  seq_state_e       state_q, state_d;
  logic             src_q, src_d;
  logic             is_div_q, is_div_d;
  logic             mult_sel_q, mult_sel_d;
  logic             div_sel_q, div_sel_d;
  md_op_e           operator_q, operator_d;
  logic [1:0]       signed_mode_q, signed_mode_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic [33:0]      imd_val_0_q, imd_val_0_d;
  logic [33:0]      imd_val_1_q, imd_val_1_d;

  logic [1:0]       grant;
  logic             grant_src;
  md_req_op_e       grant_op;
  md_decode_t       grant_dec;
  logic             unused_data_ind_timing;

  // The unit reads data_ind_timing directly; the sequencer only waits on valid_i.
  assign unused_data_ind_timing = data_ind_timing_i;

  ibex_multdiv_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .arb_en_i    (state_q == SEQ_IDLE),
    .req_valid_i (req_valid_i),
    .grant_o     (grant)
  );

  assign grant_src = grant[1];
  assign grant_op  = md_req_op_e'(req_op_i[grant_src]);
  assign grant_dec = md_decode(grant_op);

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    is_div_d      = is_div_q;
    mult_sel_d    = mult_sel_q;
    div_sel_d     = div_sel_q;
    operator_d    = operator_q;
    signed_mode_d = signed_mode_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    rsp_data_d    = rsp_data_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = err_clr_i ? 1'b0 : timeout_err_q;
    imd_val_0_d   = imd_val_we_i[0] ? imd_val_d_i_0 : imd_val_0_q;
    imd_val_1_d   = imd_val_we_i[1] ? imd_val_d_i_1 : imd_val_1_q;

    case (state_q)
      SEQ_IDLE: begin
        if (|grant) begin
          src_d         = grant_src;
          is_div_d      = grant_op[2];
          mult_sel_d    = ~grant_op[2];
          div_sel_d     = grant_op[2];
          operator_d    = grant_dec.op;
          signed_mode_d = grant_dec.signed_mode;
          op_a_d        = req_a_i[grant_src];
          op_b_d        = req_b_i[grant_src];
          wd_cnt_d      = '0;
          state_d       = SEQ_EXEC;
        end
      end
      SEQ_EXEC: begin
        if (valid_i) begin
          rsp_data_d = result_i;
          state_d    = SEQ_RESP;
        end else if (wd_cnt_q != WD_MAX) begin
          // Counter parks at WD_MAX so the flag fires once and can then be cleared.
          wd_cnt_d = wd_cnt_q + 1'b1;
          if (wd_cnt_q == WD_MAX - 1'b1) begin
            timeout_err_d = 1'b1;
          end
        end
      end
      SEQ_RESP: begin
        if (rsp_ready_i[src_q]) begin
          state_d = SEQ_IDLE;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= SEQ_IDLE;
      src_q         <= 1'b0;
      is_div_q      <= 1'b0;
      mult_sel_q    <= 1'b0;
      div_sel_q     <= 1'b0;
      operator_q    <= MD_OP_MULL;
      signed_mode_q <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      rsp_data_q    <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
      imd_val_0_q   <= '0;
      imd_val_1_q   <= '0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      is_div_q      <= is_div_d;
      mult_sel_q    <= mult_sel_d;
      div_sel_q     <= div_sel_d;
      operator_q    <= operator_d;
      signed_mode_q <= signed_mode_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      rsp_data_q    <= rsp_data_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
      imd_val_0_q   <= imd_val_0_d;
      imd_val_1_q   <= imd_val_1_d;
    end
  end

  assign req_ready_o     = grant;
  assign rsp_valid_o     = {(state_q == SEQ_RESP) && src_q, (state_q == SEQ_RESP) && !src_q};
  assign rsp_data_o      = rsp_data_q;
  assign mult_en_o       = (state_q == SEQ_EXEC) && !is_div_q;
  assign div_en_o        = (state_q == SEQ_EXEC) && is_div_q;
  assign mult_sel_o      = mult_sel_q;
  assign div_sel_o       = div_sel_q;
  assign operator_o      = operator_q;
  assign signed_mode_o   = signed_mode_q;
  assign op_a_o          = op_a_q;
  assign op_b_o          = op_b_q;
  assign equal_to_zero_o = (op_b_q == '0);
  assign imd_val_q_o_0   = imd_val_0_q;
  assign imd_val_q_o_1   = imd_val_1_q;
  assign busy_o          = (state_q != SEQ_IDLE);
  assign timeout_err_o   = timeout_err_q;

endmodule
